// File: rtl/sumrest_serial.sv
`default_nettype none
// ============================================================================
//  Module      : sumrest_serial
//  Description : Multi-cycle digit-serial adder/subtractor. Operands are
//                latched on an accepted start and summed DIGIT bits per clock
//                through a narrow adder slice with a registered carry.
//                Produces result, carry-out, signed overflow, negative and
//                zero flags, plus a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module sumrest_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sign,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sumt,
    output logic             ct,
    output logic             ovf,
    output logic             neg,
    output logic             zero
);

    localparam int NSTEPS = WIDTH / DIGIT;
    localparam int STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int MSB    = WIDTH - 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

    // Reject geometries where the slices would not tile the operand exactly.
    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("sumrest_serial: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched operands; the second operand is stored already inverted for
    // subtraction so the slice adder and the overflow rule see Bx directly.
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_bx;
    logic              r_carry;
    logic [STEP_W-1:0] r_step;

    logic              w_accept;
    logic              w_step_en;
    logic              w_last;
    int                w_base;
    logic [DIGIT-1:0]  w_a_slice;
    logic [DIGIT-1:0]  w_b_slice;
    logic [DIGIT:0]    w_slice_full;
    logic [WIDTH-1:0]  w_sum_next;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode; start is only looked at outside RUN,
    // so a request while busy is simply dropped.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step_en    = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                w_step_en = 1'b1;
                if (r_step == LAST_STEP) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Narrow adder slice: current digit of A and Bx plus the stored carry.
    always_comb begin
        w_base       = int'(r_step) * DIGIT;
        w_a_slice    = r_a[w_base +: DIGIT];
        w_b_slice    = r_bx[w_base +: DIGIT];
        w_slice_full = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{DIGIT{1'b0}}, r_carry};
    end

    // Result with the current digit merged in; on the final step this is the
    // complete sum the flags are derived from.
    always_comb begin
        w_sum_next                  = sumt;
        w_sum_next[w_base +: DIGIT] = w_slice_full[DIGIT-1:0];
    end

    // Operand capture, per-step accumulation and final flag update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_bx    <= '0;
            r_carry <= 1'b0;
            r_step  <= '0;
            sumt    <= '0;
            ct      <= 1'b0;
            ovf     <= 1'b0;
            neg     <= 1'b0;
            zero    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_bx    <= sign ? ~B : B;
            r_carry <= cin;
            r_step  <= '0;
        end else if (w_step_en) begin
            sumt    <= w_sum_next;
            r_carry <= w_slice_full[DIGIT];
            r_step  <= w_last ? '0 : (r_step + STEP_W'(1));
            if (w_last) begin
                ct   <= w_slice_full[DIGIT];
                ovf  <= (r_a[MSB] == r_bx[MSB]) && (w_sum_next[MSB] != r_a[MSB]);
                neg  <= w_sum_next[MSB];
                zero <= (w_sum_next == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sumrest_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sumrest_serial
//  Description : Bench for sumrest_serial in three geometries (8/1, 16/4, 8/8)
//                against a behavioural arithmetic/latency model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sumrest_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = 3'b000;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        sign = 1'b0;
    logic        cin = 1'b0;

    logic [2:0]  busy_v, done_v, ct_v, ovf_v, neg_v, zero_v;
    logic [7:0]  s0, s2;
    logic [15:0] s1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sumrest_serial #(.WIDTH(8), .DIGIT(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .A(A[7:0]), .B(B[7:0]),
        .sign(sign), .cin(cin), .busy(busy_v[0]), .done(done_v[0]), .sumt(s0),
        .ct(ct_v[0]), .ovf(ovf_v[0]), .neg(neg_v[0]), .zero(zero_v[0]));

    sumrest_serial #(.WIDTH(16), .DIGIT(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .A(A), .B(B),
        .sign(sign), .cin(cin), .busy(busy_v[1]), .done(done_v[1]), .sumt(s1),
        .ct(ct_v[1]), .ovf(ovf_v[1]), .neg(neg_v[1]), .zero(zero_v[1]));

    sumrest_serial #(.WIDTH(8), .DIGIT(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .A(A[7:0]), .B(B[7:0]),
        .sign(sign), .cin(cin), .busy(busy_v[2]), .done(done_v[2]), .sumt(s2),
        .ct(ct_v[2]), .ovf(ovf_v[2]), .neg(neg_v[2]), .zero(zero_v[2]));

    function automatic int wid(int d);
        return (d == 1) ? 16 : 8;
    endfunction

    function automatic int nst(int d);
        return (d == 0) ? 8 : ((d == 1) ? 4 : 1);
    endfunction

    function automatic logic [15:0] get_sum(int d);
        if (d == 0) return {8'h00, s0};
        if (d == 1) return s1;
        return {8'h00, s2};
    endfunction

    // Plain-arithmetic reference: returns {ovf, ct, sum}.
    function automatic logic [17:0] ref_add(int w, logic [15:0] a, logic [15:0] b,
                                            logic s, logic c);
        logic [16:0] mask, aa, bb, full;
        logic [15:0] sum;
        logic        co, ov;
        mask = (17'd1 << w) - 17'd1;
        aa   = {1'b0, a} & mask;
        bb   = (s ? {1'b0, ~b} : {1'b0, b}) & mask;
        full = aa + bb + {16'd0, c};
        sum  = full[15:0] & mask[15:0];
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
        return {ov, co, sum};
    endfunction

    // Model: an accepted op yields its result nst edges later, done for one
    // cycle; outputs otherwise hold; starts while an op is pending are dropped.
    int          m_rem  [3];
    logic        m_done [3];
    logic        m_ct   [3];
    logic        m_ovf  [3];
    logic        m_neg  [3];
    logic        m_zero [3];
    logic [15:0] m_sum  [3];
    logic [17:0] m_pend [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_rem[i]  <= 0;
                m_done[i] <= 1'b0;
                m_sum[i]  <= '0;
                m_ct[i]   <= 1'b0;
                m_ovf[i]  <= 1'b0;
                m_neg[i]  <= 1'b0;
                m_zero[i] <= 1'b0;
            end else if (m_rem[i] != 0) begin
                m_rem[i]  <= m_rem[i] - 1;
                m_done[i] <= (m_rem[i] == 1);
                if (m_rem[i] == 1) begin
                    m_sum[i]  <= m_pend[i][15:0];
                    m_ct[i]   <= m_pend[i][16];
                    m_ovf[i]  <= m_pend[i][17];
                    m_neg[i]  <= m_pend[i][wid(i)-1];
                    m_zero[i] <= (m_pend[i][15:0] == 16'h0000);
                end
            end else begin
                m_done[i] <= 1'b0;
                if (start_v[i]) begin
                    m_rem[i]  <= nst(i);
                    m_pend[i] <= ref_add(wid(i), A, B, sign, cin);
                end
            end
        end
    end

    task automatic chk(string nm, int d, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, d, act, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            chk("busy", d, 16'(busy_v[d]), 16'(m_rem[d] != 0));
            chk("done", d, 16'(done_v[d]), 16'(m_done[d]));
            chk("ct",   d, 16'(ct_v[d]),   16'(m_ct[d]));
            chk("ovf",  d, 16'(ovf_v[d]),  16'(m_ovf[d]));
            chk("neg",  d, 16'(neg_v[d]),  16'(m_neg[d]));
            chk("zero", d, 16'(zero_v[d]), 16'(m_zero[d]));
            if (m_rem[d] == 0) chk("sumt", d, get_sum(d), m_sum[d]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    // Launch one op on DUT d and check hand-computed results and latency.
    task automatic op_lit(int d, logic [15:0] a, logic [15:0] b, logic s, logic c,
                          logic [15:0] esum, logic ect, logic eovf, logic ezero,
                          int inject);
        int k;
        bit found;
        A = a; B = b; sign = s; cin = c;
        start_v[d] = 1'b1;
        k = 0;
        found = 1'b0;
        while (!found && k < 40) begin
            tick();
            k++;
            if (done_v[d]) found = 1'b1;
            if (k == 1) begin
                start_v[d] = 1'b0;
                A    = 16'($urandom);
                B    = 16'($urandom);
                sign = 1'($urandom_range(0, 1));
                cin  = 1'($urandom_range(0, 1));
            end
            if (inject != 0 && k == inject) begin
                start_v[d] = 1'b1;
                A = 16'hA5A5;
                B = 16'h5A5A;
            end
            if (inject != 0 && k == inject + 1) start_v[d] = 1'b0;
        end
        if (found) begin
            chk("lat",     d, 16'(k), 16'(nst(d) + 1));
            chk("lit_sum", d, get_sum(d), esum);
            chk("lit_ct",  d, 16'(ct_v[d]),   16'(ect));
            chk("lit_ovf", d, 16'(ovf_v[d]),  16'(eovf));
            chk("lit_zero",d, 16'(zero_v[d]), 16'(ezero));
            chk("lit_neg", d, 16'(neg_v[d]),  16'(esum[wid(d)-1]));
        end else begin
            total++;
            bad++;
            $display("FAIL timeout[%0d] got=no_done want=done", d);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all();
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", d, 16'(busy_v[d]), 16'h0);
            chk("rst_done", d, 16'(done_v[d]), 16'h0);
            chk("rst_sum",  d, get_sum(d), 16'h0);
            chk("rst_zero", d, 16'(zero_v[d]), 16'h0);
        end
        rst_n = 1'b1;
        tick();

        op_lit(0, 16'h35, 16'h4A, 1'b0, 1'b0, 16'h7F, 1'b0, 1'b0, 1'b0, 0);
        op_lit(0, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1, 1'b0, 0);
        op_lit(0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 0);
        op_lit(0, 16'h10, 16'h20, 1'b1, 1'b1, 16'hF0, 1'b0, 1'b0, 1'b0, 0);
        op_lit(0, 16'h55, 16'h55, 1'b1, 1'b1, 16'h00, 1'b1, 1'b0, 1'b1, 0);
        op_lit(0, 16'h80, 16'h01, 1'b1, 1'b1, 16'h7F, 1'b1, 1'b1, 1'b0, 0);

        // Start pulsed mid-run is dropped; the next op is requested in the done cycle.
        op_lit(0, 16'h35, 16'h4A, 1'b0, 1'b0, 16'h7F, 1'b0, 1'b0, 1'b0, 3);
        op_lit(0, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1, 1'b0, 0);
        tick();

        // Reset in the middle of an operation.
        A = 16'h0033; B = 16'h0011; sign = 1'b0; cin = 1'b0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_busy", 0, 16'(busy_v[0]), 16'h0);
        chk("mrst_done", 0, 16'(done_v[0]), 16'h0);
        chk("mrst_sum",  0, get_sum(0), 16'h0);
        chk("mrst_flag", 0, {12'h0, ct_v[0], ovf_v[0], neg_v[0], zero_v[0]}, 16'h0);
        rst_n = 1'b1;
        repeat (10) tick();
        op_lit(0, 16'h35, 16'h4A, 1'b0, 1'b0, 16'h7F, 1'b0, 1'b0, 1'b0, 0);

        op_lit(1, 16'h1234, 16'hEDCC, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        op_lit(1, 16'h7000, 16'h1000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
        op_lit(2, 16'h12, 16'h34, 1'b0, 1'b0, 16'h46, 1'b0, 1'b0, 1'b0, 0);
        op_lit(2, 16'h80, 16'h80, 1'b0, 1'b0, 16'h00, 1'b1, 1'b1, 1'b1, 0);

        // Random traffic on all three units at once.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) start_v[i] = ($urandom_range(0, 2) == 0);
            A     = 16'($urandom);
            B     = 16'($urandom);
            sign  = 1'($urandom_range(0, 1));
            cin   = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
        end
        start_v = 3'b000;
        rst_n   = 1'b1;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sumrest_serial.md
Name: sumrest_serial

Overview:
- Parametrised, multi-cycle adder/subtractor; successor to the 4-bit combinational add/sub stage.
- Operands are latched on a start handshake and processed DIGIT bits per clock through an internal DIGIT-bit adder slice with a registered carry.
- Produces the result plus carry, signed-overflow, negative and zero flags, with a done pulse.
- Used in the lab datapath where a narrow adder must serve wide operands.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be at least 2 and a multiple of DIGIT; any other value is an elaboration error.
- DIGIT, 1, bits processed per clock. NSTEPS = WIDTH/DIGIT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a new operation; sampled only when not busy.
- A  input  WIDTH  first operand, sampled on accepted start.
- B  input  WIDTH  second operand, sampled on accepted start.
- sign  input  1  0 = add, 1 = subtract; sampled on accepted start.
- cin  input  1  carry-in for cascading; sampled on accepted start.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse when result and flags become valid.
- sumt  output  WIDTH  result.
- ct  output  1  final carry-out.
- ovf  output  1  signed (two's-complement) overflow.
- neg  output  1  equals sumt[WIDTH-1].
- zero  output  1  high when sumt == 0.

Behaviour:
- Arithmetic, modulo 2^WIDTH:
  - sign = 0: {ct, sumt} = A + B + cin.
  - sign = 1: {ct, sumt} = A + ~B + cin. So cin = 1 gives A - B; ct = 1 means no borrow.
  - Let Bx = B when adding and ~B when subtracting. ovf = (A[msb] == Bx[msb]) && (sumt[msb] != A[msb]).
- Reset (rst_n low at a clock edge):
  - State goes to IDLE.
  - busy = 0, done = 0, sumt = 0, ct = 0, ovf = 0, neg = 0, zero = 0 (zero is forced low in reset).
  - Step counter = 0, carry register = 0.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- State machine:
  - IDLE:
    - start = 1 at edge T latches A, Bx and the carry register (= cin).
    - Go to RUN with step = 0.
  - RUN:
    - Each cycle adds slice [step*DIGIT +: DIGIT] of A and Bx plus the carry register.
    - The sum is written to the same slice of sumt and the carry register is updated.
    - On the final step (step = NSTEPS-1), go to DONE.
    - RUN occupies edges T+1 .. T+NSTEPS.
  - DONE:
    - At the edge ending the final step (T+NSTEPS), ct, ovf, neg and zero update.
    - done is high during the cycle after edge T+NSTEPS, for exactly one cycle.
    - Next state is IDLE, or a new RUN if start = 1 (back-to-back acceptance: latches new operands, no idle cycle).
- Latency: done is high NSTEPS+1 cycles after the accepting edge T.
- busy:
  - High from edge T through the last RUN cycle.
  - Low in DONE and IDLE.
  - start while busy = 1 is ignored; it is neither queued nor allowed to corrupt the latched operands.
- Output hold:
  - sumt and the flags hold their last valid values until the next accepted operation.
  - During RUN, sumt shows partially updated slices and must not be used until done.
  - Flags hold their old values during RUN.
- Input changes after the accepting edge have no effect on the running operation.
- DIGIT = WIDTH gives a single-step (NSTEPS = 1) unit: done 2 cycles after start.

Test Plan:
- WIDTH=8, DIGIT=1, add, A=0x35, B=0x4A, cin=0 -> sumt=0x7F, ct=0, ovf=0, neg=0, zero=0. busy high for 8 cycles, then done pulses 9 cycles after the accepting edge.
- Add, A=0x7F, B=0x01, cin=0 -> sumt=0x80, ovf=1, neg=1, ct=0. Add, A=0xFF, B=0x01 -> sumt=0x00, ct=1, zero=1, ovf=0.
- Subtract, cin=1: A=0x10, B=0x20 -> sumt=0xF0, ct=0, neg=1. A=0x55, B=0x55 -> sumt=0x00, ct=1, zero=1. A=0x80, B=0x01 -> sumt=0x7F, ovf=1.
- Pulse start with different operands in the middle of a RUN -> the first result is unchanged and no extra done occurs. Then assert start during the DONE cycle -> a second operation runs immediately with correct latency.
- Drive rst_n low at step 4 of an operation -> all outputs 0 at the next edge, no done. A fresh start then completes normally.
- WIDTH=16, DIGIT=4, add, A=0x1234, B=0xEDCC, cin=0 -> sumt=0x0000, ct=1, zero=1, done 5 cycles after accept. Also run WIDTH=8, DIGIT=8 and check done 2 cycles after accept.
